// File: rtl/bram_controller_rr.sv
// Round-robin controller sharing one single-port 32-bit BRAM among NUM_PORTS valid/ready masters.
// Define BRAM_CTRL_INIT_PATTERN_EN to preload word i with value i; otherwise the BRAM starts zeroed.
module bram_controller_rr #(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PORTS-1:0]    mem_valid,
  output logic [NUM_PORTS-1:0]    mem_ready,
  input  logic [NUM_PORTS*32-1:0] mem_addr,
  input  logic [NUM_PORTS*32-1:0] mem_wdata,
  input  logic [NUM_PORTS*4-1:0]  mem_wstrb,
  output logic [31:0]             mem_rdata
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef logic [DEPTH-1:0][31:0] mem_t;

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef BRAM_CTRL_INIT_PATTERN_EN
      m[ADDR_W'(i)] = 32'(i);
`else
      m[ADDR_W'(i)] = 32'h0000_0000;
`endif
    end
    return m;
  endfunction

  // Contents survive reset; only the elaboration-time image is defined.
  mem_t mem = init_mem();

  state_t           state;
  state_t           state_next;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] grant_p0;
  logic             accept;

  logic             req_any;
  logic [PTR_W-1:0] winner;
  int               cand;

  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_wstrb;
  logic             addr_unused;

  logic [ADDR_W-1:0] idx_p0;
  logic [31:0]       wdata_p0;
  logic [3:0]        wstrb_p0;

  // Search ptr, ptr+1, ... so the port after the last winner gets first chance.
  always_comb begin
    req_any = 1'b0;
    winner  = ptr;
    cand    = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!req_any && (p == cand) && mem_valid[p]) begin
          req_any = 1'b1;
          winner  = PTR_W'(p);
        end
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (PTR_W'(p) == winner) begin
        sel_addr  = mem_addr[32*p +: 32];
        sel_wdata = mem_wdata[32*p +: 32];
        sel_wstrb = mem_wstrb[4*p +: 4];
      end
    end
  end

  // Byte offset and bits above the word index are ignored, so addresses alias.
  assign addr_unused = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mem_ready  = '0;
    case (state)
      IDLE: begin
        if (req_any) begin
          accept     = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (PTR_W'(p) == grant_p0) mem_ready[p] = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // p0: request latched at the IDLE acceptance edge
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p0   <= sel_addr[ADDR_W+1:2];
      wdata_p0 <= sel_wdata;
      wstrb_p0 <= sel_wstrb;
    end
  end

  // p1: BRAM access edge; an async reset before this edge leaves state != ACCESS, discarding the write
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_p0[b]) mem[idx_p0][8*b +: 8] <= wdata_p0[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_p0  <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_next;
      if (accept) grant_p0 <= winner;
      if (state == ACCESS) mem_rdata <= mem[idx_p0];
      if (state == RESP) begin
        ptr <= (grant_p0 == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_p0 + 1'b1;
      end
    end
  end

endmodule
